// File: rtl/serial_mem_port.sv
// Serial memory port: turns one parallel load/store request into MSB-first
// address/data byte transfers on a narrow handshaked bus, with a per-byte wait timeout.
module serial_mem_port #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              ard_data_ready,
  input  logic              ard_receive_ready,
  input  logic [BUS_W-1:0]  in_bus,
  output logic [BUS_W-1:0]  out_bus,
  output logic              bus_mar,
  output logic              bus_mdr,
  output logic              bus_wr
);

  localparam int unsigned NA     = ADDR_W / BUS_W;
  localparam int unsigned ND     = DATA_W / BUS_W;
  localparam int unsigned NMAX   = (NA > ND) ? NA : ND;
  localparam int unsigned CNT_W  = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_ADDR,
    SEND_DATA,
    RECV_DATA,
    RESP
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nx;
  logic [DATA_W-1:0]   rd_shift, rd_shift_nx;
  logic [ADDR_W-1:0]   addr_sh, addr_sh_nx;
  logic [DATA_W-1:0]   data_sh, data_sh_nx;
  logic                write_q, write_nx;

  logic                hs_c;
  logic                last_c;
  logic                timeout_hit;

  logic                req_ready_nx;
  logic                rsp_valid_nx;
  logic                rsp_err_nx;
  logic [DATA_W-1:0]   rsp_rdata_nx;
  logic [BUS_W-1:0]    out_bus_nx;
  logic                bus_mar_nx;
  logic                bus_mdr_nx;
  logic                bus_wr_nx;

  // State and registered outputs; outputs are loaded with the values of the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      rd_shift  <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      write_q   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      out_bus   <= '0;
      bus_mar   <= 1'b0;
      bus_mdr   <= 1'b0;
      bus_wr    <= 1'b0;
    end else begin
      state     <= state_nx;
      byte_cnt  <= byte_cnt_nx;
      wait_cnt  <= wait_cnt_nx;
      rd_shift  <= rd_shift_nx;
      addr_sh   <= addr_sh_nx;
      data_sh   <= data_sh_nx;
      write_q   <= write_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_rdata <= rsp_rdata_nx;
      out_bus   <= out_bus_nx;
      bus_mar   <= bus_mar_nx;
      bus_mdr   <= bus_mdr_nx;
      bus_wr    <= bus_wr_nx;
    end
  end

  // Next-state, counters, shift registers and next output values.
  always_comb begin
    state_nx     = state;
    byte_cnt_nx  = byte_cnt;
    wait_cnt_nx  = wait_cnt;
    rd_shift_nx  = rd_shift;
    addr_sh_nx   = addr_sh;
    data_sh_nx   = data_sh;
    write_nx     = write_q;
    hs_c         = 1'b0;
    last_c       = 1'b0;
    timeout_hit  = 1'b0;

    // Handshake source and last-byte position depend on the transfer phase.
    case (state)
      SEND_ADDR: begin
        hs_c   = ard_receive_ready;
        last_c = (byte_cnt == CNT_W'(NA - 1));
      end
      SEND_DATA: begin
        hs_c   = ard_receive_ready;
        last_c = (byte_cnt == CNT_W'(ND - 1));
      end
      RECV_DATA: begin
        hs_c   = ard_data_ready;
        last_c = (byte_cnt == CNT_W'(ND - 1));
      end
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nx    = SEND_ADDR;
          addr_sh_nx  = req_addr;
          data_sh_nx  = req_wdata;
          write_nx    = req_write;
          byte_cnt_nx = '0;
          wait_cnt_nx = '0;
        end
      end
      SEND_ADDR, SEND_DATA, RECV_DATA: begin
        if (hs_c) begin
          wait_cnt_nx = '0;
          if (state == SEND_ADDR) addr_sh_nx = addr_sh << BUS_W;
          if (state == SEND_DATA) data_sh_nx = data_sh << BUS_W;
          if (state == RECV_DATA) rd_shift_nx = (rd_shift << BUS_W) | DATA_W'(in_bus);
          if (last_c) begin
            byte_cnt_nx = '0;
            if (state == SEND_ADDR) state_nx = write_q ? SEND_DATA : RECV_DATA;
            else                    state_nx = RESP;
          end else begin
            byte_cnt_nx = byte_cnt + CNT_W'(1);
          end
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row: abort.
          state_nx    = RESP;
          timeout_hit = 1'b1;
          byte_cnt_nx = '0;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    req_ready_nx = (state_nx == IDLE);
    rsp_valid_nx = (state_nx == RESP);
    rsp_err_nx   = timeout_hit;
    rsp_rdata_nx = ((state_nx == RESP) && !timeout_hit && !write_q) ? rd_shift_nx : '0;
    bus_mar_nx   = (state_nx == SEND_ADDR);
    bus_mdr_nx   = (state_nx == SEND_DATA);
    bus_wr_nx    = (bus_mar_nx || bus_mdr_nx) ? write_nx : 1'b0;
    if (state_nx == SEND_ADDR)      out_bus_nx = addr_sh_nx[ADDR_W-1 -: BUS_W];
    else if (state_nx == SEND_DATA) out_bus_nx = data_sh_nx[DATA_W-1 -: BUS_W];
    else                            out_bus_nx = '0;
  end

endmodule
